gerador_posicao_6: RTL and testbench

//  Computes the next 6-bit grid position (8x8 board, pos[5:3]=row, pos[2:0]=col) once per game step.

---
 rtl/gerador_posicao_6_pkg.sv | 68 ++++++
 rtl/gerador_posicao_6_contador_passo.sv | 49 ++++
 rtl/gerador_posicao_6.sv | 155 +++++++++++++++
 tb/tb_gerador_posicao_6.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gerador_posicao_6_pkg.sv
// gerador_posicao_6_pkg: shared game constants, direction/state codes and the grid step rule.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package gerador_posicao_6_pkg;

   localparam int LARGURA_EIXO = 3;                   // bits per board axis (8x8 board)
   localparam int LARGURA_POS  = 2 * LARGURA_EIXO;    // packed {row, col}

   typedef enum logic [1:0] {
      DIR_CIMA     = 2'b00,
      DIR_BAIXO    = 2'b01,
      DIR_ESQUERDA = 2'b10,
      DIR_DIREITA  = 2'b11
   } direcao_t;

   typedef enum logic [2:0] {
      ST_PARADO   = 3'd0,
      ST_INICIA   = 3'd1,
      ST_CONTANDO = 3'd2,
      ST_CALCULA  = 3'd3,
      ST_ESCREVE  = 3'd4,
      ST_FIM      = 3'd5
   } estado_t;

   typedef struct packed {
      logic [LARGURA_EIXO-1:0] linha;
      logic [LARGURA_EIXO-1:0] coluna;
   } pos_t;

   // Result of one step: the wrapped position plus a flag telling whether the
   // move crossed the board border (only acted on when the border is a wall).
   typedef struct packed {
      pos_t pos;
      logic borda;
   } passo_t;

   // Opposite directions differ only in the LSB (cima<->baixo, esquerda<->direita).
   function automatic direcao_t oposta(direcao_t d);
      return direcao_t'({d[1], ~d[0]});
   endfunction

   // 3-bit arithmetic wraps naturally modulo 8; borda flags the wrap.
   function automatic passo_t calcula_passo(pos_t p, direcao_t d);
      passo_t r;
      r.pos   = p;
      r.borda = 1'b0;
      case (d)
         DIR_CIMA: begin
            r.pos.linha = p.linha - 3'd1;
            r.borda     = (p.linha == 3'd0);
         end
         DIR_BAIXO: begin
            r.pos.linha = p.linha + 3'd1;
            r.borda     = (p.linha == 3'd7);
         end
         DIR_ESQUERDA: begin
            r.pos.coluna = p.coluna - 3'd1;
            r.borda      = (p.coluna == 3'd0);
         end
         default: begin
            r.pos.coluna = p.coluna + 3'd1;
            r.borda      = (p.coluna == 3'd7);
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gerador_posicao_6_contador_passo.sv
// gerador_posicao_6_contador_passo: modulo-MODULO tick counter pacing the game steps.
// Latency: fim is combinational, high in the cycle the counter sits at MODULO-1 while counting.
// Backpressure: conta=0 freezes the count; zera clears it and has priority over conta.
//
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high
//   zera   in  clear the count on the next edge
//   conta  in  advance the count this cycle
//   fim    out terminal count reached while counting (count wraps to 0 on that edge)
module gerador_posicao_6_contador_passo #(
   parameter int MODULO = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1;

   logic [W-1:0] cont_q;
   logic [W-1:0] cont_d;

   always_comb begin
      cont_d = cont_q;
      fim    = 1'b0;
      if (zera) begin
         cont_d = '0;
      end else if (conta) begin
         if (cont_q == W'(MODULO - 1)) begin
            cont_d = '0;
            fim    = 1'b1;
         end else begin
            cont_d = cont_q + W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

endmodule

// File: rtl/gerador_posicao_6.sv
// gerador_posicao_6: computes the next 8x8 grid position once per game step and drives the position register.
// Latency: step period PASSO_CICLOS+2 cycles (count, CALCULA, ESCREVE); register loads on the edge ending ESCREVE.
// Backpressure: pausar freezes the step counter in CONTANDO only; an in-flight CALCULA/ESCREVE always completes.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset (overrides everything)
//   iniciar           start pulse, honoured in PARADO or FIM
//   pausar            level, holds the step counter
//   botoes[3:0]       {cima, baixo, esquerda, direita}, debounced levels
//   pos_atual[5:0]    Q of the downstream position register ({row, col})
//   pos_prox[5:0]     D of the downstream position register
//   escreve_pos       register enable, single-cycle pulse (INICIA and ESCREVE)
//   direcao[1:0]      committed direction
//   colisao           border collision flag (MODO_BORDA=1)
//   db_estado[2:0]    FSM state code
module gerador_posicao_6
   import gerador_posicao_6_pkg::*;
#(
   parameter int         PASSO_CICLOS = 25_000_000,   // must be >= 2
   parameter logic [5:0] POS_INICIAL  = 6'b100_100,
   parameter bit         MODO_BORDA   = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       pausar,
   input  logic [3:0] botoes,
   input  logic [5:0] pos_atual,
   output logic [5:0] pos_prox,
   output logic       escreve_pos,
   output logic [1:0] direcao,
   output logic       colisao,
   output logic [2:0] db_estado
);

   estado_t  estado_q,   estado_d;
   direcao_t direcao_q,  direcao_d;
   direcao_t dir_pend_q, dir_pend_d;
   pos_t     pos_prox_q, pos_prox_d;
   logic     colisao_q,  colisao_d;

   logic     zera_cont;
   logic     conta_cont;
   logic     fim_passo;

   logic     botao_vld;
   direcao_t botao_dir;
   passo_t   passo;

   gerador_posicao_6_contador_passo #(
      .MODULO (PASSO_CICLOS)
   ) u_contador_passo (
      .clock (clock),
      .reset (reset),
      .zera  (zera_cont),
      .conta (conta_cont),
      .fim   (fim_passo)
   );

   // Fixed priority: cima > baixo > esquerda > direita.
   always_comb begin
      botao_vld = |botoes;
      botao_dir = DIR_DIREITA;
      if (botoes[3]) begin
         botao_dir = DIR_CIMA;
      end else if (botoes[2]) begin
         botao_dir = DIR_BAIXO;
      end else if (botoes[1]) begin
         botao_dir = DIR_ESQUERDA;
      end
   end

   assign passo = calcula_passo(pos_t'(pos_atual), dir_pend_q);

   always_comb begin
      estado_d    = estado_q;
      direcao_d   = direcao_q;
      pos_prox_d  = pos_prox_q;
      colisao_d   = colisao_q;
      zera_cont   = 1'b0;
      conta_cont  = 1'b0;
      escreve_pos = 1'b0;

      case (estado_q)
         ST_PARADO, ST_FIM: begin
            // pos_prox is loaded on entry so it is already valid during the INICIA write pulse
            if (iniciar) begin
               estado_d   = ST_INICIA;
               pos_prox_d = pos_t'(POS_INICIAL);
            end
         end
         ST_INICIA: begin
            escreve_pos = 1'b1;
            colisao_d   = 1'b0;
            direcao_d   = DIR_DIREITA;
            zera_cont   = 1'b1;
            estado_d    = ST_CONTANDO;
         end
         ST_CONTANDO: begin
            conta_cont = ~pausar;
            if (fim_passo) begin
               estado_d = ST_CALCULA;
            end
         end
         ST_CALCULA: begin
            direcao_d = dir_pend_q;
            if (MODO_BORDA && passo.borda) begin
               colisao_d = 1'b1;
               estado_d  = ST_FIM;
            end else begin
               pos_prox_d = passo.pos;
               estado_d   = ST_ESCREVE;
            end
         end
         ST_ESCREVE: begin
            escreve_pos = 1'b1;
            estado_d    = ST_CONTANDO;
         end
         default: begin
            estado_d = ST_PARADO;
         end
      endcase

      // Reversal is judged against the direction committed after this edge, so a
      // button pressed during CALCULA can never queue a U-turn of the new heading.
      dir_pend_d = dir_pend_q;
      if (estado_q == ST_INICIA) begin
         dir_pend_d = DIR_DIREITA;
      end else if (botao_vld && (botao_dir != oposta(direcao_d))) begin
         dir_pend_d = botao_dir;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= ST_PARADO;
         direcao_q  <= DIR_DIREITA;
         dir_pend_q <= DIR_DIREITA;
         pos_prox_q <= '0;
         colisao_q  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         direcao_q  <= direcao_d;
         dir_pend_q <= dir_pend_d;
         pos_prox_q <= pos_prox_d;
         colisao_q  <= colisao_d;
      end
   end

   assign pos_prox  = pos_prox_q;
   assign direcao   = direcao_q;
   assign colisao   = colisao_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_gerador_posicao_6.sv
module tb_gerador_posicao_6;

   localparam int         PASSO   = 4;
   localparam logic [5:0] POS_INI = 6'd36;

   localparam int PH_IDLE  = 0;
   localparam int PH_START = 1;
   localparam int PH_COUNT = 2;
   localparam int PH_CALC  = 3;
   localparam int PH_WRITE = 4;

   typedef struct {
      int cyc;
      int pos;
      int dir;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic            iniciar;
   logic            pausar;
   logic [3:0]      botoes;
   logic [1:0][5:0] pos_atual_w;
   logic [1:0][5:0] pos_prox_w;
   logic [1:0]      escreve_w;
   logic [1:0][1:0] direcao_w;
   logic [1:0]      colisao_w;
   logic [1:0][2:0] estado_w;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   exp_t q0[$];
   exp_t q1[$];

   // reference model state, one slot per instance (0: wrap, 1: wall)
   int m_ph[2];
   int m_cnt[2];
   int m_dir[2];
   int m_pend[2];
   int m_coll[2];
   int m_reg[2];
   int m_nxt[2];

   gerador_posicao_6 #(.PASSO_CICLOS(PASSO), .POS_INICIAL(POS_INI), .MODO_BORDA(1'b0)) u_wrap (
      .clock(clk), .reset(reset), .iniciar(iniciar), .pausar(pausar), .botoes(botoes),
      .pos_atual(pos_atual_w[0]), .pos_prox(pos_prox_w[0]), .escreve_pos(escreve_w[0]),
      .direcao(direcao_w[0]), .colisao(colisao_w[0]), .db_estado(estado_w[0])
   );

   gerador_posicao_6 #(.PASSO_CICLOS(PASSO), .POS_INICIAL(POS_INI), .MODO_BORDA(1'b1)) u_wall (
      .clock(clk), .reset(reset), .iniciar(iniciar), .pausar(pausar), .botoes(botoes),
      .pos_atual(pos_atual_w[1]), .pos_prox(pos_prox_w[1]), .escreve_pos(escreve_w[1]),
      .direcao(direcao_w[1]), .colisao(colisao_w[1]), .db_estado(estado_w[1])
   );

   // downstream position registers
   always @(posedge clk) begin
      if (reset) begin
         pos_atual_w <= '0;
      end else begin
         if (escreve_w[0]) pos_atual_w[0] <= pos_prox_w[0];
         if (escreve_w[1]) pos_atual_w[1] <= pos_prox_w[1];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Highest-priority pressed button becomes pending unless it is the U-turn of ref_dir.
   function automatic int pick(int pend, int ref_dir, logic [3:0] bot);
      int want;
      int opp;
      if (bot == 4'b0000) return pend;
      want = bot[3] ? 0 : (bot[2] ? 1 : (bot[1] ? 2 : 3));
      opp  = (ref_dir < 2) ? (1 - ref_dir) : (5 - ref_dir);
      if (want == opp) return pend;
      return want;
   endfunction

   task automatic push_exp(int k, int pos, int dir);
      exp_t e;
      e.cyc = cyc;
      e.pos = pos;
      e.dir = dir;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model_reset(int k);
      m_ph[k]   = PH_IDLE;
      m_cnt[k]  = 0;
      m_dir[k]  = 3;
      m_pend[k] = 3;
      m_coll[k] = 0;
      m_reg[k]  = 0;
      m_nxt[k]  = 0;
   endtask

   // One clock cycle of the game rules for instance k with the inputs held this cycle.
   task automatic model(int k, bit ini, bit pau, logic [3:0] bot, bit rst);
      int r;
      int c;
      int d;
      case (m_ph[k])
         PH_IDLE: begin
            m_pend[k] = pick(m_pend[k], m_dir[k], bot);
            if (ini) m_ph[k] = PH_START;
         end
         PH_START: begin
            push_exp(k, POS_INI, m_dir[k]);
            m_coll[k] = 0;
            m_dir[k]  = 3;
            m_pend[k] = 3;
            m_cnt[k]  = 0;
            m_reg[k]  = POS_INI;
            m_ph[k]   = PH_COUNT;
         end
         PH_COUNT: begin
            m_pend[k] = pick(m_pend[k], m_dir[k], bot);
            if (!pau) begin
               m_cnt[k]++;
               if (m_cnt[k] == PASSO) begin
                  m_cnt[k] = 0;
                  m_ph[k]  = PH_CALC;
               end
            end
         end
         PH_CALC: begin
            d = m_pend[k];
            m_dir[k]  = d;
            m_pend[k] = pick(m_pend[k], d, bot);
            r = m_reg[k] / 8;
            c = m_reg[k] % 8;
            if (d == 0)      r = r - 1;
            else if (d == 1) r = r + 1;
            else if (d == 2) c = c - 1;
            else             c = c + 1;
            if (k == 1 && (r < 0 || r > 7 || c < 0 || c > 7)) begin
               m_coll[k] = 1;
               m_ph[k]   = PH_IDLE;
            end else begin
               m_nxt[k] = ((r + 8) % 8) * 8 + ((c + 8) % 8);
               m_ph[k]  = PH_WRITE;
            end
         end
         default: begin
            push_exp(k, m_nxt[k], m_dir[k]);
            m_pend[k] = pick(m_pend[k], m_dir[k], bot);
            m_reg[k]  = m_nxt[k];
            m_ph[k]   = PH_COUNT;
         end
      endcase
      if (rst) model_reset(k);
   endtask

   // Called #1 after a rising edge: checks registered flags, drives this cycle's inputs, advances the model.
   task automatic drive_cycle(bit ini, bit pau, logic [3:0] bot, bit rst);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("colisao u%0d", k), int'(colisao_w[k]), m_coll[k]);
         check($sformatf("direcao u%0d", k), int'(direcao_w[k]), m_dir[k]);
      end
      iniciar = ini;
      pausar  = pau;
      botoes  = bot;
      reset   = rst;
      model(0, ini, pau, bot, rst);
      model(1, ini, pau, bot, rst);
   endtask

   task automatic tick(bit ini, bit pau, logic [3:0] bot, bit rst);
      @(posedge clk);
      #1;
      drive_cycle(ini, pau, bot, rst);
   endtask

   task automatic mon_one(int k);
      exp_t e;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
         n_vec++;
         n_err++;
         $display("FAIL write_unexpected u%0d: escreve_pos=1 pos_prox=%0d at cycle %0d, none expected",
                  k, pos_prox_w[k], cyc);
         return;
      end
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("write_cycle u%0d", k), cyc, e.cyc);
      check($sformatf("write_pos u%0d", k), int'(pos_prox_w[k]), e.pos);
      check($sformatf("write_dir u%0d", k), int'(direcao_w[k]), e.dir);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (escreve_w[0] === 1'b1) mon_one(0);
         if (escreve_w[1] === 1'b1) mon_one(1);
      end
   end

   task automatic check_reset_outputs(string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s estado u%0d", tag, k), int'(estado_w[k]), 0);
         check($sformatf("%s escreve u%0d", tag, k), int'(escreve_w[k]), 0);
         check($sformatf("%s pos_prox u%0d", tag, k), int'(pos_prox_w[k]), 0);
         check($sformatf("%s direcao u%0d", tag, k), int'(direcao_w[k]), 3);
         check($sformatf("%s colisao u%0d", tag, k), int'(colisao_w[k]), 0);
      end
   endtask

   initial begin
      bit found;
      reset   = 1'b1;
      iniciar = 1'b0;
      pausar  = 1'b0;
      botoes  = 4'b0000;
      model_reset(0);
      model_reset(1);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      mon_en = 1'b1;
      drive_cycle(1'b0, 1'b0, 4'b0000, 1'b0);

      // start and drift right: wrap instance 36,37,38,39,32; wall instance stops at col 7
      tick(1'b1, 1'b0, 4'b0000, 1'b0);
      repeat (30) tick(1'b0, 1'b0, 4'b0000, 1'b0);
      check("wall estado FIM", int'(estado_w[1]), 5);
      check("wall pos held", int'(pos_atual_w[1]), 39);
      check("wrap pos 39->32", int'(pos_atual_w[0]), 32);

      // reversal: esquerda ignored, cima accepted, then baixo ignored
      repeat (8)  tick(1'b0, 1'b0, 4'b0010, 1'b0);
      repeat (6)  tick(1'b0, 1'b0, 4'b1000, 1'b0);
      repeat (12) tick(1'b0, 1'b0, 4'b0100, 1'b0);
      check("reversal pos", int'(pos_atual_w[0]), 10);
      check("reversal dir", int'(direcao_w[0]), 0);

      // restart the wall instance, then head up through the top edge
      tick(1'b1, 1'b0, 4'b0000, 1'b0);
      repeat (60) tick(1'b0, 1'b0, 4'b1000, 1'b0);

      // pause for 20 cycles, then resume
      repeat (20) tick(1'b0, 1'b1, 4'b0000, 1'b0);
      repeat (20) tick(1'b0, 1'b0, 4'b0000, 1'b0);

      // reset landing on an ESCREVE cycle
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         #1;
         if (estado_w[0] == 3'd4) begin
            found = 1'b1;
            drive_cycle(1'b0, 1'b0, 4'b0000, 1'b1);
         end else begin
            drive_cycle(1'b0, 1'b0, 4'b0000, 1'b0);
         end
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL escreve_wait: no ESCREVE state within 40 cycles, state=%0d", estado_w[0]);
      end
      @(posedge clk);
      #1;
      check_reset_outputs("reset_in_escreve");
      drive_cycle(1'b0, 1'b0, 4'b0000, 1'b0);

      // randomized play
      for (int i = 0; i < 3000; i++) begin
         bit          ini;
         bit          pau;
         bit          rst;
         logic [3:0]  bot;
         ini = ($urandom_range(0, 99) < 3);
         pau = ($urandom_range(0, 99) < 15);
         rst = ($urandom_range(0, 999) < 3);
         bot = ($urandom_range(0, 99) < 65) ? 4'b0000 : 4'($urandom_range(1, 15));
         tick(ini, pau, bot, rst);
      end

      repeat (12) tick(1'b0, 1'b0, 4'b0000, 1'b0);
      @(negedge clk);
      check("leftover writes u0", q0.size(), 0);
      check("leftover writes u1", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
